// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp_pkg
//  Brief    : Shared constants and FSM state encoding for the multi-port
//             register file (default width/count, CLEAR/READY states).
//  Revision : 1.0  initial release
// ============================================================================
package regfile_mp_pkg;

    // Default register width and register count
    localparam int RF_REG_W   = 32;
    localparam int RF_REG_NUM = 32;

    // Post-reset clear sequencer states
    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage : regfile_mp_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Brief    : One busy bit per register. Issue sets a bit, a write to the
//             register clears it; a same-edge set beats the clear. Lookups
//             see a same-cycle write-clear but not a same-cycle set.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int REG_NUM = RF_REG_NUM,
    parameter int NRD     = 2,
    parameter int AW      = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        we,
    input  logic [2*AW-1:0]   waddr,
    input  logic              bset,
    input  logic [AW-1:0]     bset_addr,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    rbusy
);

    logic [REG_NUM-1:0] r_busy;
    logic [AW-1:0]      w_waddr0;
    logic [AW-1:0]      w_waddr1;

    assign w_waddr0 = waddr[0  +: AW];
    assign w_waddr1 = waddr[AW +: AW];

    // Busy bit update: set has priority over a write-clear; bit 0 never sets
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else if (en) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (bset && (bset_addr == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if ((we[0] && (w_waddr0 == AW'(i))) ||
                             (we[1] && (w_waddr1 == AW'(i)))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rbusy
        logic [AW-1:0] w_raddr;
        logic          w_bit;

        assign w_raddr = raddr[k*AW +: AW];

        // Busy lookup with write-clear bypass; forced low outside READY
        always_comb begin
            w_bit = 1'b0;
            if (en && (w_raddr != '0)) begin
                w_bit = r_busy[w_raddr] &
                        ~((we[0] && (w_waddr0 == w_raddr)) ||
                          (we[1] && (w_waddr1 == w_raddr)));
            end
        end

        assign rbusy[k] = w_bit;
    end

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Brief    : Multi-read, dual-write register file with x0 hard-wired to 0,
//             same-cycle write bypass, a busy scoreboard and a post-reset
//             sequencer that zeroes registers 1..REG_NUM-1 one per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int REG_W   = RF_REG_W,
    parameter int REG_NUM = RF_REG_NUM,
    parameter int NRD     = 2,
    parameter int AW      = $clog2(REG_NUM)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NRD*AW-1:0]    raddr_i,
    output logic [NRD*REG_W-1:0] rdata_o,
    output logic [NRD-1:0]       rbusy_o,
    input  logic [1:0]           we_i,
    input  logic [2*AW-1:0]      waddr_i,
    input  logic [2*REG_W-1:0]   wdata_i,
    input  logic                 bset_i,
    input  logic [AW-1:0]        bset_addr_i,
    output logic                 ready_o
);

    rf_state_e      r_state;
    logic [AW-1:0]  r_clr_idx;
    logic           r_ready;
    logic [REG_W-1:0] r_regs [REG_NUM];

    logic [AW-1:0]    w_waddr0;
    logic [AW-1:0]    w_waddr1;
    logic [REG_W-1:0] w_wdata0;
    logic [REG_W-1:0] w_wdata1;
    logic             w_active;
    logic [1:0]       w_we;
    logic             w_bset;

    assign w_waddr0 = waddr_i[0  +: AW];
    assign w_waddr1 = waddr_i[AW +: AW];
    assign w_wdata0 = wdata_i[0     +: REG_W];
    assign w_wdata1 = wdata_i[REG_W +: REG_W];

    // All user traffic is gated off until the clear sequence has finished
    assign w_active = (r_state == RF_READY);
    assign w_we     = w_active ? we_i : 2'b00;
    assign w_bset   = w_active & bset_i;

    // Clear sequencer: walk index 1..REG_NUM-1, then park in READY
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= RF_CLEAR;
            r_clr_idx <= AW'(1);
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                RF_CLEAR: begin
                    if (r_clr_idx == AW'(REG_NUM - 1)) begin
                        r_state <= RF_READY;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                RF_READY: begin
                    r_state <= RF_READY;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state   <= RF_CLEAR;
                    r_clr_idx <= AW'(1);
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // Register storage (no reset): clear writes in CLEAR, user writes in
    // READY; port 1 is issued second so it wins a same-address collision
    always_ff @(posedge clk_i) begin
        if (r_state == RF_CLEAR) begin
            r_regs[r_clr_idx] <= '0;
        end else begin
            if (w_we[0] && (w_waddr0 != '0)) begin
                r_regs[w_waddr0] <= w_wdata0;
            end
            if (w_we[1] && (w_waddr1 != '0)) begin
                r_regs[w_waddr1] <= w_wdata1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    w_raddr;
        logic [REG_W-1:0] w_rdata;

        assign w_raddr = raddr_i[k*AW +: AW];

        // Zero-latency read with write bypass (port 1 over port 0)
        always_comb begin
            w_rdata = '0;
            if (w_active && (w_raddr != '0)) begin
                if (w_we[1] && (w_waddr1 == w_raddr)) begin
                    w_rdata = w_wdata1;
                end else if (w_we[0] && (w_waddr0 == w_raddr)) begin
                    w_rdata = w_wdata0;
                end else begin
                    w_rdata = r_regs[w_raddr];
                end
            end
        end

        assign rdata_o[k*REG_W +: REG_W] = w_rdata;
    end

    regfile_scoreboard #(
        .REG_NUM (REG_NUM),
        .NRD     (NRD),
        .AW      (AW)
    ) u_scoreboard (
        .clk       (clk_i),
        .rst       (rst_i),
        .en        (w_active),
        .we        (w_we),
        .waddr     (waddr_i),
        .bset      (w_bset),
        .bset_addr (bset_addr_i),
        .raddr     (raddr_i),
        .rbusy     (rbusy_o)
    );

    assign ready_o = r_ready;

endmodule : regfile_mp
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter REG_W, default `RegW (32), register width in bits.
REQ-002 SHALL have parameter REG_NUM, default `RegNum (32), register count.
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter AW, default $clog2(REG_NUM), address width.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port raddr_i, input, NRD*AW, packed read addresses with port k at [k*AW +: AW].
REQ-008 SHALL have port rdata_o, output, NRD*REG_W, packed read data.
REQ-009 SHALL have port rbusy_o, output, NRD, scoreboard busy bit of each read address.
REQ-010 SHALL have port we_i, input, 2, write enables for write ports 0 and 1.
REQ-011 SHALL have port waddr_i, input, 2*AW, packed write addresses.
REQ-012 SHALL have port wdata_i, input, 2*REG_W, packed write data.
REQ-013 SHALL have port bset_i, input, 1, marks register bset_addr_i busy (instruction issue).
REQ-014 SHALL have port bset_addr_i, input, AW, address to mark busy.
REQ-015 SHALL have port ready_o, output, 1, high once the post-reset clear completes.

Function
REQ-016 SHALL keep register 0 at 0: ignore writes to address 0, read it as 0, and never set its busy bit.
REQ-017 SHALL perform enabled writes on the clk_i rising edge, with write port 1 winning when both ports target the same address.
REQ-018 SHALL read combinationally, with zero latency.
REQ-019 SHALL bypass writes: if an enabled write targets a nonzero read address in the same cycle, rdata_o returns that wdata, port-1 data taking priority over port-0.
REQ-020 SHALL keep one busy bit per register, set on the clock edge by bset_i and cleared on the clock edge by any enabled write to that address.
REQ-021 SHALL resolve a same-cycle busy set and write-clear on the same address as set (busy stays 1).
REQ-022 SHALL make rbusy_o a combinational busy lookup that already reflects a same-cycle write-clear (bypass) but not a same-cycle set.
REQ-023 SHALL implement a two-state FSM: CLEAR → READY.
REQ-024 SHALL in CLEAR write 0 to one index per cycle, 1 up to REG_NUM-1, via an internal counter, then enter READY.
REQ-025 SHALL in CLEAR ignore we_i and bset_i and hold rdata_o and rbusy_o at 0.
REQ-026 SHALL reach READY REG_NUM-1 cycles after rst_i deasserts.
REQ-027 SHALL drive ready_o high only in READY.
REQ-028 SHALL in READY never return to CLEAR except via rst_i.

Reset
REQ-029 SHALL on rst_i asynchronously set the FSM to CLEAR, the clear counter to 1, all busy bits to 0 and ready_o to 0.
REQ-030 SHALL leave register contents unreset by rst_i itself (CLEAR zeroes them).
REQ-031 SHALL restart the clear from index 1 if rst_i asserts mid-CLEAR or in READY.

Structure
REQ-032 SHALL take REG_W/REG_NUM defaults and the FSM state encodings (`RF_CLEAR, `RF_READY) from the shared common.vh header.
REQ-033 SHALL isolate the busy-bit array and its set/clear/bypass logic in one sub-module, regfile_scoreboard.

Verification
REQ-034 SHALL verify: rst_i pulse, then count cycles → ready_o rises exactly 31 cycles after deassert, and raddr=5 reads 0.
REQ-035 SHALL verify: same-cycle write x7=0xDEADBEEF with raddr_i port0=7 → rdata port0=0xDEADBEEF in that cycle, and again the next cycle.
REQ-036 SHALL verify: both write ports target x3 with 0x11/0x22 → x3=0x22 afterwards.
REQ-037 SHALL verify: write x0=0xFFFFFFFF, bset_i on x0 → reads 0 and rbusy 0.
REQ-038 SHALL verify: bset x9, then a later write x9 coinciding with a new bset x9 → busy stays 1, and rbusy_o=0 in the write-only clear cycle.
REQ-039 SHALL verify: rst_i asserted at clear index 10, then writes attempted during CLEAR → writes ignored, clear restarts from index 1, ready_o rises 31 cycles after deassert.
